// File: rtl/trap_ctrl_if.sv
// Bundle of IDU, CSR-file and timer-bus signals seen by trap_ctrl.
// Member names mirror the controller's signal list; slave is the controller side.
interface trap_ctrl_if;
    logic        tc_inst_valid_i;
    logic [63:0] tc_pc_i;
    logic        tc_is_ecall_i;
    logic        tc_is_mret_i;
    logic        tc_mstatus_mie_i;
    logic        tc_mie_mtie_i;
    logic [63:0] tc_mtvec_i;
    logic [63:0] tc_mepc_i;
    logic        tc_tmr_wen_i;
    logic        tc_tmr_addr_i;
    logic [63:0] tc_tmr_wdata_i;
    logic [63:0] tc_tmr_rdata_o;
    logic [1:0]  tc_excepttype_o;
    logic [63:0] tc_exceptpc_o;
    logic        tc_stall_o;
    logic        tc_redirect_o;
    logic [63:0] tc_redirect_pc_o;
    logic        tc_mtip_o;

    modport master (
        output tc_inst_valid_i, tc_pc_i, tc_is_ecall_i, tc_is_mret_i,
        output tc_mstatus_mie_i, tc_mie_mtie_i, tc_mtvec_i, tc_mepc_i,
        output tc_tmr_wen_i, tc_tmr_addr_i, tc_tmr_wdata_i,
        input  tc_tmr_rdata_o, tc_excepttype_o, tc_exceptpc_o, tc_stall_o,
        input  tc_redirect_o, tc_redirect_pc_o, tc_mtip_o
    );

    modport slave (
        input  tc_inst_valid_i, tc_pc_i, tc_is_ecall_i, tc_is_mret_i,
        input  tc_mstatus_mie_i, tc_mie_mtie_i, tc_mtvec_i, tc_mepc_i,
        input  tc_tmr_wen_i, tc_tmr_addr_i, tc_tmr_wdata_i,
        output tc_tmr_rdata_o, tc_excepttype_o, tc_exceptpc_o, tc_stall_o,
        output tc_redirect_o, tc_redirect_pc_o, tc_mtip_o
    );
endinterface

// File: rtl/trap_ctrl.sv
// Trap entry/exit sequencer for the single-cycle core, plus the machine timer
// (mtime/mtimecmp with a clock prescaler).
module trap_ctrl #(
    parameter int unsigned TMR_DIV      = 1,
    parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input logic        tc_clk_i,
    input logic        tc_rst_n_i,
    trap_ctrl_if.slave tc_bus_io
);

    typedef enum logic [1:0] {StRun, StEntry, StHandler, StExit} state_e;

    localparam logic [1:0]  CauseNone  = 2'd0;
    localparam logic [1:0]  CauseEcall = 2'd1;
    localparam logic [1:0]  CauseMret  = 2'd2;
    localparam logic [1:0]  CauseTimer = 2'd3;
    localparam logic [15:0] PreMax     = 16'(TMR_DIV - 1);

    state_e      state_q, state_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [15:0] pre_q, pre_d;
    logic [63:0] epc_q, epc_d;
    logic [1:0]  cause_q, cause_d;

    logic        mtip;
    logic        stall;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic [1:0]  excepttype;
    logic [63:0] exceptpc;

    always_ff @(posedge tc_clk_i) begin
        if (!tc_rst_n_i) begin
            state_q    <= StRun;
            mtime_q    <= '0;
            mtimecmp_q <= MTIMECMP_RST;
            pre_q      <= '0;
            epc_q      <= '0;
            cause_q    <= CauseNone;
        end else begin
            state_q    <= state_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            pre_q      <= pre_d;
            epc_q      <= epc_d;
            cause_q    <= cause_d;
        end
    end

    // Timer: a software write to mtime overrides the tick and restarts the prescaler.
    always_comb begin
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        pre_d      = pre_q;
        if (pre_q == PreMax) begin
            pre_d   = '0;
            mtime_d = mtime_q + 64'd1;
        end else begin
            pre_d = pre_q + 16'd1;
        end
        if (tc_bus_io.tc_tmr_wen_i) begin
            if (tc_bus_io.tc_tmr_addr_i) begin
                mtimecmp_d = tc_bus_io.tc_tmr_wdata_i;
            end else begin
                mtime_d = tc_bus_io.tc_tmr_wdata_i;
                pre_d   = '0;
            end
        end
    end

    assign mtip = (mtime_q >= mtimecmp_q);

    always_comb begin
        state_d     = state_q;
        epc_d       = epc_q;
        cause_d     = cause_q;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        excepttype  = CauseNone;
        exceptpc    = '0;
        unique case (state_q)
            StRun, StHandler: begin
                // Timer is masked while a handler runs, whatever MIE says.
                if (tc_bus_io.tc_inst_valid_i) begin
                    if (state_q == StRun && mtip && tc_bus_io.tc_mstatus_mie_i &&
                        tc_bus_io.tc_mie_mtie_i) begin
                        stall   = 1'b1;
                        epc_d   = tc_bus_io.tc_pc_i;
                        cause_d = CauseTimer;
                        state_d = StEntry;
                    end else if (tc_bus_io.tc_is_ecall_i) begin
                        stall   = 1'b1;
                        epc_d   = tc_bus_io.tc_pc_i;
                        cause_d = CauseEcall;
                        state_d = StEntry;
                    end else if (tc_bus_io.tc_is_mret_i) begin
                        stall   = 1'b1;
                        epc_d   = tc_bus_io.tc_pc_i;
                        cause_d = CauseMret;
                        state_d = StExit;
                    end
                end
            end
            StEntry: begin
                excepttype  = cause_q;
                exceptpc    = epc_q;
                redirect    = 1'b1;
                redirect_pc = {tc_bus_io.tc_mtvec_i[63:2], 2'b00};
                stall       = 1'b1;
                state_d     = StHandler;
            end
            StExit: begin
                excepttype  = CauseMret;
                redirect    = 1'b1;
                redirect_pc = tc_bus_io.tc_mepc_i;
                stall       = 1'b1;
                state_d     = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    // Trap outputs are masked while reset is held so a reset mid-ENTRY/EXIT emits nothing.
    assign tc_bus_io.tc_excepttype_o  = tc_rst_n_i ? excepttype : CauseNone;
    assign tc_bus_io.tc_exceptpc_o    = tc_rst_n_i ? exceptpc : '0;
    assign tc_bus_io.tc_stall_o       = tc_rst_n_i & stall;
    assign tc_bus_io.tc_redirect_o    = tc_rst_n_i & redirect;
    assign tc_bus_io.tc_redirect_pc_o = tc_rst_n_i ? redirect_pc : '0;
    assign tc_bus_io.tc_mtip_o        = mtip;
    assign tc_bus_io.tc_tmr_rdata_o   = tc_bus_io.tc_tmr_addr_i ? mtimecmp_q : mtime_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: expectations queued per cycle, checked at the falling edge.
module tb_trap_ctrl;

    localparam int SigType  = 0;
    localparam int SigEpc   = 1;
    localparam int SigStall = 2;
    localparam int SigRedir = 3;
    localparam int SigRpc   = 4;
    localparam int SigMtip  = 5;
    localparam int SigRdata = 6;
    localparam int SigRd4   = 7;
    localparam int SigMtip4 = 8;

    localparam logic [63:0] Ones = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct {
        string       tag;
        int          sig;
        logic [63:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    trap_ctrl_if bus1 ();
    trap_ctrl_if bus4 ();

    trap_ctrl #(.TMR_DIV(1)) dut (
        .tc_clk_i  (clk),
        .tc_rst_n_i(rst_n),
        .tc_bus_io (bus1.slave)
    );

    trap_ctrl #(.TMR_DIV(4)) dut4 (
        .tc_clk_i  (clk),
        .tc_rst_n_i(rst_n),
        .tc_bus_io (bus4.slave)
    );

    function automatic logic [63:0] observe(int sig);
        case (sig)
            SigType:  return 64'(bus1.tc_excepttype_o);
            SigEpc:   return bus1.tc_exceptpc_o;
            SigStall: return 64'(bus1.tc_stall_o);
            SigRedir: return 64'(bus1.tc_redirect_o);
            SigRpc:   return bus1.tc_redirect_pc_o;
            SigMtip:  return 64'(bus1.tc_mtip_o);
            SigRdata: return bus1.tc_tmr_rdata_o;
            SigRd4:   return bus4.tc_tmr_rdata_o;
            SigMtip4: return 64'(bus4.tc_mtip_o);
            default:  return 'x;
        endcase
    endfunction

    task automatic exp_sig(input string tag, input int sig, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic exp_quiet(input string tag);
        exp_sig({tag, ".type"}, SigType, 64'd0);
        exp_sig({tag, ".stall"}, SigStall, 64'd0);
        exp_sig({tag, ".redir"}, SigRedir, 64'd0);
    endtask

    // Check everything queued for this cycle, then advance to just after the next rising edge.
    task automatic cyc();
        exp_t        e;
        logic [63:0] o;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = observe(e.sig);
            n_vec++;
            assert (o === e.val)
            else begin
                n_err++;
                $display("FAIL %s: observed %h expected %h", e.tag, o, e.val);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus1.tc_inst_valid_i  = 1'b0;
        bus1.tc_pc_i          = '0;
        bus1.tc_is_ecall_i    = 1'b0;
        bus1.tc_is_mret_i     = 1'b0;
        bus1.tc_mstatus_mie_i = 1'b0;
        bus1.tc_mie_mtie_i    = 1'b0;
        bus1.tc_mtvec_i       = 64'h8000_0101;
        bus1.tc_mepc_i        = '0;
        bus1.tc_tmr_wen_i     = 1'b0;
        bus1.tc_tmr_addr_i    = 1'b0;
        bus1.tc_tmr_wdata_i   = '0;
        bus4.tc_inst_valid_i  = 1'b0;
        bus4.tc_pc_i          = '0;
        bus4.tc_is_ecall_i    = 1'b0;
        bus4.tc_is_mret_i     = 1'b0;
        bus4.tc_mstatus_mie_i = 1'b0;
        bus4.tc_mie_mtie_i    = 1'b0;
        bus4.tc_mtvec_i       = '0;
        bus4.tc_mepc_i        = '0;
        bus4.tc_tmr_wen_i     = 1'b0;
        bus4.tc_tmr_addr_i    = 1'b0;
        bus4.tc_tmr_wdata_i   = '0;

        @(posedge clk);
        #1;
        exp_quiet("rst");
        exp_sig("rst.mtip", SigMtip, 64'd0);
        exp_sig("rst.mtime", SigRdata, 64'd0);
        cyc();

        // Free-running timer after reset release
        rst_n = 1'b1;
        exp_sig("run.mtime0", SigRdata, 64'd0);
        cyc();
        repeat (4) cyc();
        exp_sig("run.mtime5", SigRdata, 64'd5);
        exp_sig("run.mtip", SigMtip, 64'd0);
        exp_quiet("run");
        cyc();

        // Ecall from RUN
        bus1.tc_inst_valid_i = 1'b1;
        bus1.tc_is_ecall_i   = 1'b1;
        bus1.tc_pc_i         = 64'h8000_0010;
        exp_sig("ecall.det.stall", SigStall, 64'd1);
        exp_sig("ecall.det.redir", SigRedir, 64'd0);
        exp_sig("ecall.det.type", SigType, 64'd0);
        cyc();
        bus1.tc_inst_valid_i = 1'b0;
        bus1.tc_is_ecall_i   = 1'b0;
        exp_sig("ecall.ent.type", SigType, 64'd1);
        exp_sig("ecall.ent.epc", SigEpc, 64'h8000_0010);
        exp_sig("ecall.ent.redir", SigRedir, 64'd1);
        exp_sig("ecall.ent.rpc", SigRpc, 64'h8000_0100);
        exp_sig("ecall.ent.stall", SigStall, 64'd1);
        cyc();
        exp_quiet("ecall.hdl");
        cyc();

        // mtimecmp write; timer pending but masked in HANDLER
        bus1.tc_tmr_wen_i   = 1'b1;
        bus1.tc_tmr_addr_i  = 1'b1;
        bus1.tc_tmr_wdata_i = 64'd3;
        exp_sig("cmpwr.mtip_old", SigMtip, 64'd0);
        cyc();
        bus1.tc_tmr_wen_i = 1'b0;
        exp_sig("cmpwr.rdata", SigRdata, 64'd3);
        exp_sig("cmpwr.mtip", SigMtip, 64'd1);
        cyc();
        bus1.tc_tmr_addr_i    = 1'b0;
        bus1.tc_mstatus_mie_i = 1'b1;
        bus1.tc_mie_mtie_i    = 1'b1;
        bus1.tc_inst_valid_i  = 1'b1;
        bus1.tc_pc_i          = 64'h8000_0020;
        exp_quiet("hdl.notimer");
        cyc();

        // mret out of the handler
        bus1.tc_is_mret_i = 1'b1;
        bus1.tc_pc_i      = 64'h8000_0030;
        bus1.tc_mepc_i    = 64'h8000_0040;
        exp_sig("mret.det.stall", SigStall, 64'd1);
        exp_sig("mret.det.redir", SigRedir, 64'd0);
        cyc();
        bus1.tc_inst_valid_i = 1'b0;
        bus1.tc_is_mret_i    = 1'b0;
        exp_sig("mret.exit.type", SigType, 64'd2);
        exp_sig("mret.exit.redir", SigRedir, 64'd1);
        exp_sig("mret.exit.rpc", SigRpc, 64'h8000_0040);
        exp_sig("mret.exit.stall", SigStall, 64'd1);
        cyc();

        // Timer retaken in RUN; beats an ecall at the same pc
        bus1.tc_inst_valid_i = 1'b1;
        bus1.tc_is_ecall_i   = 1'b1;
        bus1.tc_pc_i         = 64'h8000_0040;
        exp_sig("tmr.det.stall", SigStall, 64'd1);
        exp_sig("tmr.det.redir", SigRedir, 64'd0);
        cyc();
        bus1.tc_inst_valid_i = 1'b0;
        bus1.tc_is_ecall_i   = 1'b0;
        exp_sig("tmr.ent.type", SigType, 64'd3);
        exp_sig("tmr.ent.epc", SigEpc, 64'h8000_0040);
        exp_sig("tmr.ent.rpc", SigRpc, 64'h8000_0100);
        exp_sig("tmr.ent.redir", SigRedir, 64'd1);
        cyc();

        // mtime write, then mtime == mtimecmp boundary
        bus1.tc_tmr_wen_i   = 1'b1;
        bus1.tc_tmr_wdata_i = 64'd2;
        cyc();
        bus1.tc_tmr_wen_i = 1'b0;
        exp_sig("mtwr.rdata", SigRdata, 64'd2);
        exp_sig("mtwr.mtip", SigMtip, 64'd0);
        cyc();
        exp_sig("mteq.rdata", SigRdata, 64'd3);
        exp_sig("mteq.mtip", SigMtip, 64'd1);
        cyc();

        // Leave handler, idle in RUN with timer pending, then take it
        bus1.tc_inst_valid_i = 1'b1;
        bus1.tc_is_mret_i    = 1'b1;
        exp_sig("mret2.det.stall", SigStall, 64'd1);
        cyc();
        bus1.tc_inst_valid_i = 1'b0;
        bus1.tc_is_mret_i    = 1'b0;
        exp_sig("mret2.exit.type", SigType, 64'd2);
        cyc();
        exp_quiet("idle.run");
        cyc();
        bus1.tc_inst_valid_i = 1'b1;
        bus1.tc_pc_i         = 64'h8000_0050;
        exp_sig("tmr2.det.stall", SigStall, 64'd1);
        cyc();

        // Reset held during ENTRY
        bus1.tc_inst_valid_i = 1'b0;
        rst_n                = 1'b0;
        exp_quiet("rstent");
        exp_sig("rstent.rpc", SigRpc, 64'd0);
        exp_sig("rstent.epc", SigEpc, 64'd0);
        cyc();
        rst_n              = 1'b1;
        bus1.tc_tmr_addr_i = 1'b1;
        exp_quiet("postrst");
        exp_sig("postrst.cmp", SigRdata, Ones);
        exp_sig("postrst.mtip", SigMtip, 64'd0);
        cyc();
        bus1.tc_tmr_addr_i   = 1'b0;
        bus1.tc_inst_valid_i = 1'b1;
        bus1.tc_is_ecall_i   = 1'b1;
        bus1.tc_pc_i         = 64'h8000_0060;
        exp_sig("postrst.ecall.stall", SigStall, 64'd1);
        cyc();
        bus1.tc_inst_valid_i = 1'b0;
        bus1.tc_is_ecall_i   = 1'b0;
        exp_sig("postrst.ent.type", SigType, 64'd1);
        exp_sig("postrst.ent.epc", SigEpc, 64'h8000_0060);
        cyc();

        // TMR_DIV=4: wrap from all-ones, then a write in the wrap cycle
        bus4.tc_tmr_wen_i   = 1'b1;
        bus4.tc_tmr_wdata_i = Ones;
        cyc();
        bus4.tc_tmr_wen_i = 1'b0;
        exp_sig("div4.ones", SigRd4, Ones);
        exp_sig("div4.mtip_eq", SigMtip4, 64'd1);
        cyc();
        exp_sig("div4.hold1", SigRd4, Ones);
        cyc();
        cyc();
        exp_sig("div4.hold3", SigRd4, Ones);
        cyc();
        exp_sig("div4.wrap", SigRd4, 64'd0);
        exp_sig("div4.mtip_wrap", SigMtip4, 64'd0);
        cyc();
        cyc();
        cyc();
        bus4.tc_tmr_wen_i   = 1'b1;
        bus4.tc_tmr_wdata_i = 64'h55;
        exp_sig("div4.prewr", SigRd4, 64'd0);
        cyc();
        bus4.tc_tmr_wen_i = 1'b0;
        exp_sig("div4.wrwins", SigRd4, 64'h55);
        cyc();
        cyc();
        cyc();
        exp_sig("div4.prehold", SigRd4, 64'h55);
        cyc();
        exp_sig("div4.tick", SigRd4, 64'h56);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Sequences trap entry and exit for the single-cycle core and owns the machine timer (mtime/mtimecmp).
- Decides, once per retiring instruction, whether an ecall, mret or timer interrupt is taken.
- Drives the CSR file's exception-type and exception-PC inputs for one cycle per event, then redirects the fetch PC to mtvec or mepc.
- Sits between IDU (decode flags, PC) and the CSR file (mtvec, mepc, MIE, MTIE).

Parameters:
- TMR_DIV, 1, mtime increments once every TMR_DIV clocks (legal range 1..65535).
- MTIMECMP_RST, 64'hFFFF_FFFF_FFFF_FFFF, reset value of mtimecmp.

Ports:
- tc_clk_i  in  1  clock
- tc_rst_n_i  in  1  reset
- tc_inst_valid_i  in  1  current instruction retires this cycle
- tc_pc_i  in  64  PC of current instruction
- tc_is_ecall_i  in  1  current instruction is ecall
- tc_is_mret_i  in  1  current instruction is mret
- tc_mstatus_mie_i  in  1  mstatus.MIE from CSR file
- tc_mie_mtie_i  in  1  mie.MTIE from CSR file
- tc_mtvec_i  in  64  mtvec from CSR file
- tc_mepc_i  in  64  mepc from CSR file
- tc_tmr_wen_i  in  1  timer register write strobe
- tc_tmr_addr_i  in  1  0 = mtime, 1 = mtimecmp
- tc_tmr_wdata_i  in  64  timer write data
- tc_tmr_rdata_o  out  64  timer read data (combinational on tc_tmr_addr_i)
- tc_excepttype_o  out  2  to CSR file: 0 none, 1 ecall, 2 mret, 3 timer_intr
- tc_exceptpc_o  out  64  to CSR file: trapping PC
- tc_stall_o  out  1  hold PC and suppress all architectural writes this cycle
- tc_redirect_o  out  1  load tc_redirect_pc_o into PC this cycle
- tc_redirect_pc_o  out  64  redirect target
- tc_mtip_o  out  1  timer interrupt pending

Behaviour:
- Interface: one clock, tc_clk_i. Reset tc_rst_n_i is synchronous and active-low.
- Reset values: state=RUN, mtime=0, prescaler=0, mtimecmp=MTIMECMP_RST, latched pc/cause=0. All outputs are 0.
- Timer:
  - Prescaler counts 0..TMR_DIV-1. On wrap, mtime += 1, with 64-bit wrap from all-ones to 0.
  - tc_mtip_o = (mtime >= mtimecmp), unsigned compare on registered values.
  - A write to mtime replaces that cycle's increment and clears the prescaler. The written value is visible the next cycle.
  - A write to mtimecmp takes effect next cycle, so tc_mtip_o can drop the cycle after the write.
- Trap condition in RUN, evaluated only when tc_inst_valid_i=1. Priority:
  1. timer: tc_mtip_o & tc_mstatus_mie_i & tc_mie_mtie_i. Pre-empts the instruction, even if that instruction is an ecall or mret.
  2. ecall
  3. mret
- Detection cycle:
  - tc_stall_o=1 combinationally, so the instruction does not commit.
  - Latch tc_pc_i and cause.
  - Next state: ENTRY for timer or ecall, EXIT for mret.
- ENTRY (1 cycle):
  - tc_excepttype_o = latched cause (3 or 1); tc_exceptpc_o = latched pc.
  - tc_redirect_o=1, tc_redirect_pc_o = {tc_mtvec_i[63:2], 2'b00}; tc_stall_o=1.
  - Next state: HANDLER.
- HANDLER:
  - Behaves like RUN, except the timer is not taken, even if MIE was re-enabled by a CSR write.
  - ecall in HANDLER is taken (cause 1, state → ENTRY; the nested mepc overwrite is accepted).
  - mret → detection as above, then EXIT.
- EXIT (1 cycle):
  - tc_excepttype_o=2, tc_redirect_o=1, tc_redirect_pc_o=tc_mepc_i, tc_stall_o=1.
  - Next state: RUN.
  - A timer pending at that moment is taken on the next valid instruction in RUN, at the earliest 1 cycle later.
- tc_inst_valid_i=0: no trap, and the state advances only out of ENTRY/EXIT.
- Reset mid-ENTRY or mid-EXIT: return to RUN with no exception type emitted. The CSR file is reset in the same cycle.
- tc_tmr_rdata_o = tc_tmr_addr_i ? mtimecmp : mtime.

Test Plan:
- Reset, then 5 clocks, TMR_DIV=1 → mtime reads 5, tc_mtip_o=0, all trap outputs 0.
- Ecall at pc=0x8000_0010, mtvec=0x8000_0101 → detect cycle stall=1; next cycle excepttype=1, exceptpc=0x8000_0010, redirect to 0x8000_0100; state HANDLER.
- mtimecmp=3, MIE=MTIE=1, valid instruction at pc=0x8000_0040 when mtime=3 → excepttype=3, exceptpc=0x8000_0040; with an ecall at the same pc, the timer wins.
- In HANDLER with MIE forced 1 and mtip=1 → no timer trap; mret with mepc=0x8000_0040 → excepttype=2, redirect 0x8000_0040, then timer retaken on the next valid instruction.
- TMR_DIV=4, write mtime=0xFFFF_FFFF_FFFF_FFFF → wraps to 0 after 4 clocks; a write in the wrap cycle wins.
- Assert reset during ENTRY → next cycle all outputs 0, state RUN, mtimecmp=MTIMECMP_RST.
